// File: rtl/pixel_stream_tx.sv
// Streams one WIDTH x HEIGHT 8-bit frame from a 1-cycle-latency frame memory to a
// ready/valid pixel sink, using a small prefetch FIFO to absorb read latency.
module pixel_stream_tx #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_go,
    output logic              o_busy,
    output logic              o_done,
    output logic [7:0]        o_frame_cnt,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_q,
    input  logic              i_ready,
    output logic [7:0]        o_pixel,
    output logic              o_valid,
    output logic              o_start
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_rd_idx;
    logic [ADDR_W-1:0] r_pop_idx;
    logic              r_in_flight;
    logic [7:0]        r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        r_frame_cnt;

    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_rd;
    logic              w_go_acc;
    logic [CNT_W:0]    w_pending;

    // Reads are throttled on occupancy plus the one outstanding read, so a pop in the
    // same cycle is never counted on and the FIFO cannot overflow.
    assign w_empty   = (r_count == '0);
    assign w_pending = {1'b0, r_count} + {{CNT_W{1'b0}}, r_in_flight};
    assign w_rd      = (r_state == S_FETCH) && (w_pending < DEPTH_C);
    assign w_push    = r_in_flight;
    assign w_pop     = !w_empty && i_ready;
    assign w_go_acc  = (r_state == S_IDLE) && i_frame_go;

    assign o_valid     = !w_empty;
    assign o_pixel     = r_fifo[r_rd_ptr];
    assign o_start     = !w_empty && (r_pop_idx == '0);
    assign o_frame_cnt = r_frame_cnt;
    assign mem_addr    = r_rd_idx;

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        mem_rd      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_frame_go) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = w_rd;
                if (w_rd && (r_rd_idx == LAST_IDX)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop && (r_pop_idx == LAST_IDX)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_rd_idx    <= '0;
            r_pop_idx   <= '0;
            r_in_flight <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_flight <= w_rd;
            if (w_go_acc) begin
                r_rd_idx  <= '0;
                r_pop_idx <= '0;
            end else begin
                if (w_rd && (r_rd_idx != LAST_IDX))   r_rd_idx  <= r_rd_idx + 1'b1;
                if (w_pop && (r_pop_idx != LAST_IDX)) r_pop_idx <= r_pop_idx + 1'b1;
            end
            if (r_state == S_DONE) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fifo   <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= mem_q;
                r_wr_ptr         <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx on an 8x4 frame with a behavioural 1-cycle frame memory.
module tb_pixel_stream_tx;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int AW   = 5;
    localparam int FD   = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          go    = 1'b0;
    logic          ready = 1'b0;
    logic          busy, done, mem_rd, valid, start;
    logic [7:0]    frame_cnt, pixel, mem_q;
    logic [AW-1:0] mem_addr;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int mode    = 0;
    int reads   = 0;
    int pops    = 0;

    always #5 clk = ~clk;

    pixel_stream_tx #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .FIFO_DEPTH(FD)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_go(go),
        .o_busy(busy), .o_done(done), .o_frame_cnt(frame_cnt),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q),
        .i_ready(ready), .o_pixel(pixel), .o_valid(valid), .o_start(start)
    );

    function automatic logic [7:0] pix(input int m, input int i);
        return (m == 0) ? 8'(i) : 8'((i * 7) & 255);
    endfunction

    always @(posedge clk) if (mem_rd) mem_q <= pix(mode, int'(mem_addr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            go = 1'b0;
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_no_read", 32'(mem_rd), 32'd0);
        end
    endtask

    // rdy_mode 0: ready high, 1: random. abort_at>0 asserts reset once that many pixels moved.
    task automatic stream(input int rdy_mode, input int stall_n, input int go_at,
                          input bit go_in_done, input int abort_at);
        int         cyc         = 0;
        int         exp_idx     = 0;
        int         first_valid = -1;
        int         last_xfer   = -1;
        bit         seen_done   = 1'b0;
        bit         prev_stall  = 1'b0;
        logic [7:0] prev_pix    = '0;
        logic       prev_start  = 1'b0;
        @(negedge clk);
        go    = 1'b1;
        ready = 1'b1;
        reads = 0;
        pops  = 0;
        while (!seen_done && cyc < 500) begin
            @(negedge clk);
            cyc++;
            go = (cyc == go_at);
            if (abort_at > 0 && exp_idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_ctrl_zero", 32'({busy, done, valid, start, mem_rd}), 32'd0);
                chk("abort_pixel_zero", 32'(pixel), 32'd0);
                chk("abort_addr_zero", 32'(mem_addr), 32'd0);
                chk("abort_fcnt_zero", 32'(frame_cnt), 32'd0);
                return;
            end
            if (cyc == 1) chk("busy_after_go", 32'(busy), 32'd1);
            if (mem_rd) begin
                chk("rd_not_full", 32'((reads - pops) < FD), 32'd1);
                chk("rd_addr", 32'(mem_addr), 32'(reads));
                reads++;
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(valid), 32'd1);
                chk("hold_pixel", 32'(pixel), 32'(prev_pix));
                chk("hold_start", 32'(start), 32'(prev_start));
            end
            if (done) begin
                chk("done_after_all", 32'(exp_idx), 32'(NPIX));
                chk("done_timing", 32'(cyc - last_xfer), 32'd1);
                seen_done = 1'b1;
                if (go_in_done) go = 1'b1;
            end else begin
                if (valid && first_valid < 0) begin
                    first_valid = cyc;
                    chk("first_valid_latency", 32'(cyc), 32'd3);
                end
                ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (first_valid >= 0 && cyc < first_valid + stall_n) ready = 1'b0;
                if (stall_n > 0 && cyc == first_valid + stall_n)
                    chk("stall_reads_max", 32'(reads <= FD), 32'd1);
                if (valid) chk("start_flag", 32'(start), 32'(exp_idx == 0));
                if (valid && ready) begin
                    chk("pixel", 32'(pixel), 32'(pix(mode, exp_idx)));
                    last_xfer = cyc;
                    exp_idx++;
                    pops++;
                end
                prev_stall = valid && !ready;
                prev_pix   = pixel;
                prev_start = start;
            end
        end
        chk("frame_completed", 32'(seen_done), 32'd1);
        if (rdy_mode == 0 && stall_n == 0)
            chk("gap_free", 32'(last_xfer - first_valid), 32'(NPIX - 1));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ctrl_zero", 32'({busy, done, valid, start, mem_rd}), 32'd0);
        chk("reset_pixel_zero", 32'(pixel), 32'd0);
        chk("reset_addr_zero", 32'(mem_addr), 32'd0);
        chk("reset_fcnt_zero", 32'(frame_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        mode = 0;
        stream(0, 0, 0, 1'b0, 0);
        idle(3);
        chk("fcnt_after_first", 32'(frame_cnt), 32'd1);

        stream(0, 10, 0, 1'b0, 0);
        idle(2);
        chk("fcnt_after_stall", 32'(frame_cnt), 32'd2);

        stream(0, 0, 5, 1'b1, 0);
        idle(6);
        chk("fcnt_go_ignored", 32'(frame_cnt), 32'd3);

        mode = 1;
        repeat (3) stream(1, 0, 0, 1'b0, 0);
        idle(2);
        chk("fcnt_after_random", 32'(frame_cnt), 32'd6);

        mode = 0;
        stream(0, 0, 0, 1'b0, 20);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        go    = 1'b0;
        idle(2);
        chk("fcnt_after_abort", 32'(frame_cnt), 32'd0);
        stream(0, 0, 0, 1'b0, 0);
        idle(2);
        chk("fcnt_restart", 32'(frame_cnt), 32'd1);

        stream(0, 0, 0, 1'b0, 0);
        repeat (254) stream(0, 0, 0, 1'b0, 0);
        idle(2);
        chk("fcnt_wrap", 32'(frame_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
